hitmap_fiber_tx: RTL and testbench
==================================

Name: hitmap_fiber_tx

Overview:
- Transmit end of the crate fiber hit-map protocol.
- Collects per-event hit coordinates (column x, row y) from the local cluster-finder stream, then serialises them onto the fiber word and the 16 fxch lanes.
- Frame format matches the crate mapping receivers: sync word, 16 payload cycles, tag word.
- Sits in the front-end FPGA, directly ahead of the fiber serialiser.

Parameters:
IDLE_GAP, 2, number of all-zero cycles after the tag word before the next sync; legal range 2..15, because the receiver needs 2 cycles to self-reset.
MAX_COORD, 37, largest legal x or y coordinate (38x38 map).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
hit_valid  in  1  hit present on hit_x/hit_y
hit_x  in  6  hit column, 0..MAX_COORD
hit_y  in  6  hit row, 0..MAX_COORD
hit_ready  out  1  block accepts hits (COLLECT state)
evt_end  in  1  end-of-event strobe; sampled only when hit_ready=1
evt_tag  in  10  event tag, latched with evt_end
fiber  out  16  fiber control word: sync, tag or zero
fxch00..fxch15  out  16 each  payload lanes
busy  out  1  frame in progress (SYNC/PAYLOAD/TAG/GAP)
coord_err  out  1  sticky: an out-of-range hit was dropped; cleared by rst only

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: all outputs registered and 0, except hit_ready=1. State=COLLECT, hit count=0, overflow flag=0, tag=0.
- Hit storage: 16 banks x 16 slots x 12 bits. The n-th accepted hit (n=0..255, arrival order) goes to bank n mod 16, slot n div 16. Count is 9 bits.
- Accepting a hit: a hit is accepted when hit_valid=1 and hit_ready=1.
  - If x>MAX_COORD or y>MAX_COORD: not stored, coord_err set.
  - Else if count==256: not stored, per-event overflow flag set.
  - Else: stored and count incremented.
- COLLECT:
  - hit_ready=1.
  - evt_end=1: latch evt_tag and go to SYNC. A hit accepted in the same cycle is included in this event.
- SYNC (1 cycle): fiber=16'hAAAA, all fxch=0, hit_ready=0.
- PAYLOAD (16 cycles, k=0..15):
  - fxchNN = {3'b000, 1'b1, (x-1) mod 64, (y-1) mod 64} when bank NN slot k holds a hit (16*k+NN < count).
  - Otherwise fxchNN=16'h0000.
  - fiber=0.
- TAG (1 cycle): fiber={5'b0, overflow, tag[9:0]}, all fxch=0.
- GAP (IDLE_GAP cycles): everything 0. On exit: count=0, overflow=0, return to COLLECT.
- Timing: if evt_end is sampled at edge E, then:
  - sync is driven from edge E+1;
  - payload cycle k is driven from edge E+2+k;
  - the tag is driven from edge E+18;
  - hit_ready returns to 1 from edge E+19+IDLE_GAP.
- Coordinate encoding: the -1 is modulo 64, so x=0 encodes as 6'b111111 and the receiver wraps back to 0. No saturation.
- Empty event: a full 18-cycle frame is still sent, with all payload lanes 0.
- Inputs ignored outside COLLECT: hit_valid and evt_end are not accepted and cause no side effects.
- rst mid-frame: outputs drop to 0 immediately and the partial frame is aborted. Stored hits are discarded and the block returns to COLLECT. Downstream sees a truncated frame; that is acceptable.
- Frame spacing: back-to-back events are separated by at least 20+IDLE_GAP cycles, sync to sync.

Test Plan:
1. Reset, one hit (x=5,y=14), evt_end with tag 10'h2A5 -> fiber=AAAA one cycle; payload k=0 has fxch00=16'h110D and all other lanes/cycles 0; tag cycle fiber=16'h02A5; then IDLE_GAP zero cycles; hit_ready=1 at E+19+IDLE_GAP.
2. Hit (0,0) plus hit (37,37) -> fxch00=16'h1FFF and fxch01=16'h1924 in payload k=0.
3. 300 valid hits then evt_end, tag 0 -> all 256 lane/cycle words non-zero, in arrival order by bank/slot; tag cycle fiber=16'h0400.
4. Hit (38,3), then evt_end -> coord_err=1 and stays 1; all payload zero; next frame still carries coord_err=1.
5. hit_valid and evt_end held high during a frame -> no extra hits counted; exactly one new frame starts after GAP with hit_ready asserted.
6. rst asserted at payload cycle 7 -> all outputs 0 asynchronously; after release, hit_ready=1; a new 1-hit event encodes correctly with count restarting at 0.

Source files
------------

// File: rtl/hitmap_fiber_tx.sv
// Fiber hit-map transmitter: collects up to 256 (x,y) hits per event, then
// emits sync, 16 payload cycles across 16 lanes, a tag word and an idle gap.
module hitmap_fiber_tx #(
  parameter int unsigned IDLE_GAP  = 2,
  parameter int unsigned MAX_COORD = 37
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_valid,
  input  logic [5:0]  hit_x,
  input  logic [5:0]  hit_y,
  output logic        hit_ready,
  input  logic        evt_end,
  input  logic [9:0]  evt_tag,
  output logic [15:0] fiber,
  output logic [15:0] fxch00,
  output logic [15:0] fxch01,
  output logic [15:0] fxch02,
  output logic [15:0] fxch03,
  output logic [15:0] fxch04,
  output logic [15:0] fxch05,
  output logic [15:0] fxch06,
  output logic [15:0] fxch07,
  output logic [15:0] fxch08,
  output logic [15:0] fxch09,
  output logic [15:0] fxch10,
  output logic [15:0] fxch11,
  output logic [15:0] fxch12,
  output logic [15:0] fxch13,
  output logic [15:0] fxch14,
  output logic [15:0] fxch15,
  output logic        busy,
  output logic        coord_err
);

  typedef enum logic [2:0] {S_COLLECT, S_SYNC, S_PAYLOAD, S_TAG, S_GAP} state_t;

  localparam logic [5:0] MAXC     = 6'(MAX_COORD);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP);

  state_t      state;
  logic [11:0] mem  [16][16];
  logic [15:0] lane [16];
  logic [15:0] pay  [16];
  logic [8:0]  count;
  logic        ovf;
  logic [9:0]  tag;
  logic [3:0]  slot;
  logic [3:0]  gcnt;
  logic        bad;
  logic        store;

  assign bad   = (hit_x > MAXC) || (hit_y > MAXC);
  assign store = (state == S_COLLECT) && hit_valid && !bad && !count[8];

  // Hit n lands in bank n[3:0], slot n[7:4]; storage needs no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (store) mem[count[3:0]][count[7:4]] <= {hit_x, hit_y};
  end

  always_comb begin
    for (int unsigned n = 0; n < 16; n++) begin
      pay[n] = '0;
      if ({1'b0, slot, 4'(n)} < count)
        pay[n] = {4'b0001, mem[n][slot][11:6] - 6'd1, mem[n][slot][5:0] - 6'd1};
    end
  end

  // Outputs lag the state by one edge: the state names what the next edge drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_COLLECT;
      hit_ready <= 1'b1;
      busy      <= 1'b0;
      coord_err <= 1'b0;
      fiber     <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      tag       <= '0;
      slot      <= '0;
      gcnt      <= '0;
      for (int unsigned n = 0; n < 16; n++) lane[n] <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (hit_valid) begin
            if (bad)           coord_err <= 1'b1;
            else if (count[8]) ovf       <= 1'b1;
            else               count     <= count + 9'd1;
          end
          if (evt_end) begin
            tag       <= evt_tag;
            hit_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SYNC;
          end
        end
        S_SYNC: begin
          fiber <= 16'hAAAA;
          slot  <= '0;
          state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          fiber <= '0;
          for (int unsigned n = 0; n < 16; n++) lane[n] <= pay[n];
          slot <= slot + 4'd1;
          if (slot == 4'd15) state <= S_TAG;
        end
        S_TAG: begin
          fiber <= {5'b0, ovf, tag};
          for (int unsigned n = 0; n < 16; n++) lane[n] <= '0;
          gcnt  <= '0;
          state <= S_GAP;
        end
        S_GAP: begin
          fiber <= '0;
          if (gcnt == GAP_LAST) begin
            hit_ready <= 1'b1;
            busy      <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
            state     <= S_COLLECT;
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

  assign fxch00 = lane[0];
  assign fxch01 = lane[1];
  assign fxch02 = lane[2];
  assign fxch03 = lane[3];
  assign fxch04 = lane[4];
  assign fxch05 = lane[5];
  assign fxch06 = lane[6];
  assign fxch07 = lane[7];
  assign fxch08 = lane[8];
  assign fxch09 = lane[9];
  assign fxch10 = lane[10];
  assign fxch11 = lane[11];
  assign fxch12 = lane[12];
  assign fxch13 = lane[13];
  assign fxch14 = lane[14];
  assign fxch15 = lane[15];

endmodule

// File: tb/tb_hitmap_fiber_tx.sv
// Directed bench for hitmap_fiber_tx: frame timing, lane encoding, overflow,
// coordinate errors, ignored inputs mid-frame and asynchronous reset.
module tb_hitmap_fiber_tx;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit_valid;
  logic [5:0]  hit_x;
  logic [5:0]  hit_y;
  logic        hit_ready;
  logic        evt_end;
  logic [9:0]  evt_tag;
  logic [15:0] fiber;
  logic [15:0] fx [16];
  logic        busy;
  logic        coord_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] expw [16][16];

  always #5 clk = ~clk;

  hitmap_fiber_tx #(.IDLE_GAP(GAP), .MAX_COORD(37)) dut (
    .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ready(hit_ready), .evt_end(evt_end), .evt_tag(evt_tag), .fiber(fiber),
    .fxch00(fx[0]),  .fxch01(fx[1]),  .fxch02(fx[2]),  .fxch03(fx[3]),
    .fxch04(fx[4]),  .fxch05(fx[5]),  .fxch06(fx[6]),  .fxch07(fx[7]),
    .fxch08(fx[8]),  .fxch09(fx[9]),  .fxch10(fx[10]), .fxch11(fx[11]),
    .fxch12(fx[12]), .fxch13(fx[13]), .fxch14(fx[14]), .fxch15(fx[15]),
    .busy(busy), .coord_err(coord_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] lanes_or();
    logic [15:0] r = '0;
    for (int n = 0; n < 16; n++) r = r | fx[n];
    return r;
  endfunction

  function automatic logic [15:0] enc(input logic [5:0] x, input logic [5:0] y);
    logic [5:0] xm = x - 6'd1;
    logic [5:0] ym = y - 6'd1;
    return {4'b0001, xm, ym};
  endfunction

  task automatic clr_exp();
    for (int k = 0; k < 16; k++)
      for (int n = 0; n < 16; n++) expw[k][n] = '0;
  endtask

  // Entered on the negedge after a single-cycle hit pulse.
  task automatic hit(input logic [5:0] x, input logic [5:0] y);
    hit_valid = 1'b1; hit_x = x; hit_y = y;
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  task automatic end_evt(input logic [9:0] t);
    evt_end = 1'b1; evt_tag = t;
    @(negedge clk);
    evt_end = 1'b0;
  endtask

  // Called on the negedge right after the edge that sampled evt_end.
  task automatic frame(input logic [15:0] tagw, input logic cerr);
    check("rdy_low_E", 32'(hit_ready), 32'd0);
    check("busy_E", 32'(busy), 32'd1);
    @(negedge clk);
    check("sync", 32'(fiber), 32'h0000AAAA);
    check("sync_lanes", 32'(lanes_or()), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("pay_fiber k%0d", k), 32'(fiber), 32'd0);
      for (int n = 0; n < 16; n++)
        check($sformatf("pay k%0d lane%0d", k, n), 32'(fx[n]), 32'(expw[k][n]));
    end
    @(negedge clk);
    check("tag", 32'(fiber), 32'(tagw));
    check("tag_lanes", 32'(lanes_or()), 32'd0);
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      check($sformatf("gap%0d", g), {fiber, lanes_or()}, 32'd0);
      check($sformatf("gap%0d_rdy", g), 32'(hit_ready), 32'd0);
      check($sformatf("gap%0d_busy", g), 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("rdy_back", 32'(hit_ready), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("coord_err", 32'(coord_err), 32'(cerr));
  endtask

  initial begin
    rst = 1'b1; hit_valid = 1'b0; hit_x = '0; hit_y = '0; evt_end = 1'b0; evt_tag = '0;
    @(negedge clk); @(negedge clk);
    check("rst_rdy", 32'(hit_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", {fiber, lanes_or()}, 32'd0);
    check("rst_cerr", 32'(coord_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single hit
    clr_exp(); expw[0][0] = 16'h110D;
    hit(6'd5, 6'd14);
    end_evt(10'h2A5);
    frame(16'h02A5, 1'b0);

    // 2: corner coordinates, second hit arrives with evt_end
    clr_exp(); expw[0][0] = 16'h1FFF; expw[0][1] = 16'h1924;
    hit(6'd0, 6'd0);
    hit_valid = 1'b1; hit_x = 6'd37; hit_y = 6'd37; evt_end = 1'b1; evt_tag = 10'h155;
    @(negedge clk);
    hit_valid = 1'b0; evt_end = 1'b0;
    frame(16'h0155, 1'b0);

    // 3: 300 hits, only the first 256 kept, overflow flagged
    clr_exp();
    for (int i = 0; i < 300; i++) begin
      logic [5:0] x, y;
      x = 6'(i % 38); y = 6'((i * 5 + 3) % 38);
      if (i < 256) expw[i / 16][i % 16] = enc(x, y);
      hit_valid = 1'b1; hit_x = x; hit_y = y;
      @(negedge clk);
    end
    hit_valid = 1'b0;
    end_evt(10'h000);
    frame(16'h0400, 1'b0);

    // 4: out-of-range hit dropped, sticky error, overflow cleared
    clr_exp();
    hit(6'd38, 6'd3);
    check("cerr_set", 32'(coord_err), 32'd1);
    end_evt(10'h3FF);
    frame(16'h03FF, 1'b1);

    // 5: inputs held high through a frame; exactly one hit per accepting cycle
    clr_exp(); expw[0][0] = 16'h1000;
    hit_valid = 1'b1; hit_x = 6'd1; hit_y = 6'd1; evt_end = 1'b1; evt_tag = 10'h011;
    @(negedge clk);
    frame(16'h0011, 1'b1);
    @(negedge clk);
    hit_valid = 1'b0; evt_end = 1'b0;
    frame(16'h0011, 1'b1);

    // 6: asynchronous reset during payload cycle 7
    hit(6'd9, 6'd9);
    end_evt(10'h001);
    repeat (9) @(negedge clk);
    check("busy_mid", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", {fiber, lanes_or()}, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rdy", 32'(hit_ready), 32'd1);
    check("arst_cerr", 32'(coord_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr_exp(); expw[0][0] = 16'h110D;
    hit(6'd5, 6'd14);
    end_evt(10'h2A5);
    frame(16'h02A5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
